// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA constants and types for the layer compositor slice.
//   640x480@60 timing constants (11-bit counters), the RGB332 colour type,
//   the transparent mask value, and the per-pixel timing tag that travels
//   down the compositor delay line.
package vga_pkg;

  typedef logic [7:0] rgb332_t;

  localparam logic [10:0] H_ACTIVE     = 11'd640;
  localparam logic [10:0] H_TOTAL      = 11'd800;
  localparam logic [10:0] H_SYNC_START = 11'd656;
  localparam logic [10:0] H_SYNC_END   = 11'd751;

  localparam logic [10:0] V_ACTIVE     = 11'd480;
  localparam logic [10:0] V_TOTAL      = 11'd525;
  localparam logic [10:0] V_SYNC_START = 11'd490;
  localparam logic [10:0] V_SYNC_END   = 11'd491;

  localparam rgb332_t MASK_VALUE = 8'h62;

  // Timing attributes of one requested pixel, carried alongside its colour.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } timing_t;

  // Blanked pixel with both syncs released (active-low syncs idle high).
  localparam timing_t TIMING_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/layer_compositor_if.sv
// layer_compositor_if -- pixel request/response bus between the compositor
// and its sprite/HUD responders.
//   requested_x/y : scan coordinates broadcast to every responder
//   frame_start   : one-clock pulse at (0,480)
//   layer_colors  : one RGB332 answer per layer, LAYER_LAT clocks later
// Modports: master = compositor, slave = responder side.
interface layer_compositor_if
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4
);

  logic [0:10]                    requested_x;
  logic [0:10]                    requested_y;
  logic                           frame_start;
  rgb332_t [NUM_LAYERS-1:0]       layer_colors;

  modport master (
    output requested_x,
    output requested_y,
    output frame_start,
    input  layer_colors
  );

  modport slave (
    input  requested_x,
    input  requested_y,
    input  frame_start,
    output layer_colors
  );

endinterface

// File: rtl/layer_compositor_scan_timing_gen.sv
// scan_timing_gen -- 800x525 scan counter and request-side timing decode.
//   clk, reset    : pixel clock, synchronous active-high reset
//   h_cnt, v_cnt  : registered scan position (0..799, 0..524)
//   active        : position lies inside the 640x480 visible area
//   hs_raw/vs_raw : active-low syncs for the requested position (undelayed)
//   frame_start   : high for the single clock where position is (0,480)
module scan_timing_gen
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        active,
  output logic        hs_raw,
  output logic        vs_raw,
  output logic        frame_start
);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 11'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 11'd1) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Pure decodes of the counter registers, so they line up with requested_x/y.
  assign active      = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  assign hs_raw      = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
  assign vs_raw      = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));
  assign frame_start = (h_cnt == 11'd0) && (v_cnt == V_ACTIVE);

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor -- pixel-request initiator and priority layer merger.
//   clk, reset      : pixel clock, synchronous active-high reset
//   bus (master)    : requested_x/y, frame_start out; layer_colors in
//   pixel_color     : merged RGB332 colour, 0 outside the visible area
//   vga_hs, vga_vs  : active-low syncs, delayed identically to colour
//   blank_n         : high during active video
//   collision_mask  : previous frame's per-layer collisions; present only
//                     when LAYER_COMPOSITOR_COLLISION_EN is defined
// Parameters: NUM_LAYERS (layer 0 = highest priority), LAYER_LAT (1..4,
// responder latency in clocks), BG_COLOR (used when every layer is masked).
// Total latency from a request to its output pixel is LAYER_LAT+1 clocks.
module layer_compositor
  import vga_pkg::*;
#(
  parameter int      NUM_LAYERS = 4,
  parameter int      LAYER_LAT  = 2,
  parameter rgb332_t BG_COLOR   = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  layer_compositor_if.master      bus,
  output rgb332_t                 pixel_color,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    blank_n
`ifdef LAYER_COMPOSITOR_COLLISION_EN
  , output logic [NUM_LAYERS-1:0] collision_mask
`endif
);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        req_active;
  logic        req_hs;
  logic        req_vs;
  logic        frame_start;

  scan_timing_gen u_scan (
    .clk         (clk),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (req_active),
    .hs_raw      (req_hs),
    .vs_raw      (req_vs),
    .frame_start (frame_start)
  );

  assign bus.requested_x = h_cnt;
  assign bus.requested_y = v_cnt;
  assign bus.frame_start = frame_start;

  // Timing tags wait LAYER_LAT clocks so they meet the responders' colours.
  timing_t [LAYER_LAT-1:0] dly;
  timing_t                 aligned;

  // NOTE: the delay line is reset (unlike a data pipeline) because its active
  // bit gates the output; stale stages would leak a partial line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAYER_LAT; i++) dly[i] <= TIMING_IDLE;
    end else begin
      dly[0] <= '{active: req_active, hsync: req_hs, vsync: req_vs};
      for (int i = 1; i < LAYER_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign aligned = dly[LAYER_LAT-1];

  // Priority select: scan from lowest priority up so the lowest-index
  // non-mask layer is the last assignment and wins.
  rgb332_t merged;

  // NOTE: default assignment first so every path drives merged; without it
  // the all-masked case would infer a latch.
  always_comb begin
    merged = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_colors[i] != MASK_VALUE) merged = bus.layer_colors[i];
    end
  end

  // Colour is only looked at when active, so blank-time garbage is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_color <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      blank_n     <= 1'b0;
    end else begin
      pixel_color <= aligned.active ? merged : 8'h00;
      vga_hs      <= aligned.hsync;
      vga_vs      <= aligned.vsync;
      blank_n     <= aligned.active;
    end
  end

`ifdef LAYER_COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-1:0] opaque;
  logic [NUM_LAYERS-1:0] coll_acc;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) opaque[i] = (bus.layer_colors[i] != MASK_VALUE);
  end

  // Sticky per-frame accumulator, published and cleared at frame_start. The
  // pipeline has long drained by (0,480), so the publish clock never overlaps
  // an active pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      coll_acc       <= '0;
      collision_mask <= '0;
    end else if (frame_start) begin
      collision_mask <= coll_acc;
      coll_acc       <= '0;
    end else if (aligned.active && ($countones(opaque) > 1)) begin
      coll_acc <= coll_acc | opaque;
    end
  end
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor -- self-checking bench for layer_compositor.
// A responder process answers every request LAYER_LAT clocks later; the line
// number of the request picks its behaviour (echo x, fixed priority pattern,
// all masked, random). The reference model derives scan position and the
// expected outputs from a cycle count since reset using plain arithmetic.
module tb_layer_compositor;
  import vga_pkg::*;

  localparam int      NL  = 4;
  localparam int      LAT = 3;
  localparam rgb332_t BG  = 8'h6d;
  localparam int      MID_RESET_N = 60 * 800 + 320;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  rgb332_t pixel_color;
  logic    vga_hs;
  logic    vga_vs;
  logic    blank_n;

  layer_compositor_if #(.NUM_LAYERS(NL)) bus ();

`ifdef LAYER_COMPOSITOR_COLLISION_EN
  logic [NL-1:0] collision_mask;
`endif

  layer_compositor #(
    .NUM_LAYERS (NL),
    .LAYER_LAT  (LAT),
    .BG_COLOR   (BG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .pixel_color (pixel_color),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .blank_n     (blank_n)
`ifdef LAYER_COMPOSITOR_COLLISION_EN
    , .collision_mask (collision_mask)
`endif
  );

  always #20 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          n           = 0;   // clocks since the last reset edge
  bit          armed       = 1'b0;
  bit          first_run   = 1'b1;
  int          hs_low      = 0;

  rgb332_t [NL-1:0] drv_hist [16];
  int               ry_hist  [16];
  int               rx_hist  [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic rgb332_t ref_merge(input rgb332_t [NL-1:0] c);
    for (int i = 0; i < NL; i++) if (c[i] != MASK_VALUE) return c[i];
    return BG;
  endfunction

  function automatic bit ref_active(input int m);
    return ((m % 800) < 640) && (((m / 800) % 525) < 480);
  endfunction

`ifdef LAYER_COMPOSITOR_COLLISION_EN
  logic [NL-1:0] m_acc   = '0;
  logic [NL-1:0] m_cmask = '0;
`endif

  // Monitor, model and responder: samples 1 time unit after every rising edge.
  initial begin
    bit               r;
    rgb332_t [NL-1:0] prev;
    rgb332_t [NL-1:0] nxt;
    int               m, ex, ey, rx, ry;
    bit               e_act, e_hs, e_vs;
    rgb332_t          e_pix;
    forever begin
      @(posedge clk);
      r = reset;
      #1;
      prev = drv_hist[n % 16];
      if (r) n = 0;
      else if (armed) n = n + 1;
      m = n - LAT - 1;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
      if (r) begin
        m_acc = '0;
        m_cmask = '0;
      end else if (armed) begin
        if (n >= 1 && ((n - 1) % 800) == 0 && (((n - 1) / 800) % 525) == 480) begin
          m_cmask = m_acc;
          m_acc = '0;
        end else if (m >= 0 && ref_active(m)) begin
          logic [NL-1:0] op;
          for (int i = 0; i < NL; i++) op[i] = (prev[i] != MASK_VALUE);
          if ($countones(op) >= 2) m_acc = m_acc | op;
        end
      end
`endif

      if (r) armed = 1'b1;

      if (armed) begin
        ex = n % 800;
        ey = (n / 800) % 525;
        check("req_x", 32'(bus.requested_x), ex);
        check("req_y", 32'(bus.requested_y), ey);
        check("frame_start", 32'(bus.frame_start), (ex == 0 && ey == 480) ? 1 : 0);
        if (m < 0) begin
          e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_pix = 8'h00;
        end else begin
          e_act = ref_active(m);
          e_hs  = !((m % 800) >= 656 && (m % 800) <= 751);
          e_vs  = !(((m / 800) % 525) >= 490 && ((m / 800) % 525) <= 491);
          e_pix = e_act ? ref_merge(prev) : 8'h00;
        end
        check("pixel_color", 32'(pixel_color), 32'(e_pix));
        check("blank_n", 32'(blank_n), 32'(e_act));
        check("vga_hs", 32'(vga_hs), 32'(e_hs));
        check("vga_vs", 32'(vga_vs), 32'(e_vs));
`ifdef LAYER_COMPOSITOR_COLLISION_EN
        check("collision_mask", 32'(collision_mask), 32'(m_cmask));
`endif

        // Hand-computed anchors for the model itself.
        if (r) begin
          check("rst_pixel_lit", 32'(pixel_color), 32'h00);
          check("rst_hs_lit", 32'(vga_hs), 32'h1);
          check("rst_vs_lit", 32'(vga_vs), 32'h1);
          check("rst_blank_lit", 32'(blank_n), 32'h0);
          check("rst_x_lit", 32'(bus.requested_x), 32'h0);
        end else begin
          if (n <= LAT) check("post_rst_blank_lit", 32'(blank_n), 32'h0);
          case (n)
            LAT + 1 + 5:        check("echo_x5_lit", 32'(pixel_color), 32'h05);
            LAT + 1 + 98:       check("echo_x98_bg_lit", 32'(pixel_color), 32'h6d);
            LAT + 1 + 200:      check("echo_x200_lit", 32'(pixel_color), 32'hc8);
            LAT + 1 + 655:      check("hs_655_lit", 32'(vga_hs), 32'h1);
            LAT + 1 + 656:      check("hs_656_lit", 32'(vga_hs), 32'h0);
            LAT + 1 + 700:      check("hs_700_lit", 32'(vga_hs), 32'h0);
            LAT + 1 + 810:      check("priority_lit", 32'(pixel_color), 32'he4);
            LAT + 1 + 1610: begin
              check("all_mask_pix_lit", 32'(pixel_color), 32'h6d);
              check("all_mask_blank_lit", 32'(blank_n), 32'h1);
            end
            LAT + 1 + 2300: begin
              check("blank_pix_lit", 32'(pixel_color), 32'h00);
              check("blank_blank_lit", 32'(blank_n), 32'h0);
            end
            default: ;
          endcase
          if (first_run && n >= LAT + 1 && n < LAT + 1 + 8000 && !vga_hs) hs_low++;
          if (first_run && n == LAT + 1 + 8000) check("hs_low_10_lines", hs_low, 960);
        end
      end

      // Responder: answer the request seen LAT clocks ago.
      rx_hist[n % 16] = 32'(bus.requested_x);
      ry_hist[n % 16] = 32'(bus.requested_y);
      for (int i = 0; i < NL; i++) nxt[i] = 8'($urandom);
      if (n >= LAT) begin
        rx = rx_hist[(n - LAT) % 16];
        ry = ry_hist[(n - LAT) % 16];
        case (ry % 4)
          0: for (int i = 0; i < NL; i++) nxt[i] = rgb332_t'(rx & 255);
          1: nxt = {8'h62, 8'h1f, 8'he4, 8'h62};
          2: for (int i = 0; i < NL; i++) nxt[i] = MASK_VALUE;
          default: for (int i = 0; i < NL; i++)
                     if ($urandom_range(1, 0) == 1) nxt[i] = MASK_VALUE;
        endcase
      end
      drv_hist[n % 16] = nxt;
      bus.layer_colors = nxt;
    end
  end

  // Sequencer: reset, long scan, mid-frame reset at (320,60), short rescan.
  initial begin
    bit found;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    found = 1'b0;
    for (int k = 0; k < 60000; k++) begin
      @(negedge clk);
      if (n == MID_RESET_N) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_mid_reset_point", 32'(found), 32'h1);
    check("mid_x_lit", 32'(bus.requested_x), 32'd320);
    check("mid_y_lit", 32'(bus.requested_y), 32'd60);

    first_run = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (5000) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
